// File: rtl/line_length_detector.sv
// Line-length feature extractor with hysteresis detection.
// Accumulates |x[n]-x[n-1]| over windows of 2^WIN_LOG2 samples, publishes the
// window sum, and debounces the above-threshold comparison into a detect flag.
module line_length_detector #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned WIN_LOG2 = 8,
   parameter int unsigned CNT_W    = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic signed [DATA_W-1:0]     x,
   input  logic                         x_valid,
   input  logic [DATA_W+WIN_LOG2-1:0]   threshold,
   input  logic [CNT_W-1:0]             k_on,
   input  logic [CNT_W-1:0]             k_off,
   output logic [DATA_W+WIN_LOG2-1:0]   feature,
   output logic                         feature_valid,
   output logic                         detect,
   output logic                         primed
);

   localparam int unsigned FW = DATA_W + WIN_LOG2;

   typedef enum logic [1:0] {
      QUIET     = 2'd0,
      ARMING    = 2'd1,
      ACTIVE    = 2'd2,
      RELEASING = 2'd3
   } state_t;

   state_t                    state;
   state_t                    state_nxt_c;
   logic [CNT_W-1:0]          run;
   logic [CNT_W-1:0]          run_nxt_c;
   logic                      detect_nxt_c;

   logic signed [DATA_W-1:0]  prev;
   logic [FW-1:0]             acc;
   logic [WIN_LOG2-1:0]       cnt;

   logic signed [DATA_W:0]    diff_c;
   logic [DATA_W-1:0]         absd_c;
   logic [FW-1:0]             sum_c;
   logic                      take_c;
   logic                      close_c;
   logic                      above_c;
   logic [CNT_W-1:0]          kon_c;
   logic [CNT_W-1:0]          koff_c;
   logic [CNT_W-1:0]          run_inc_c;

   // Difference at one extra bit so the full signed swing is exact, then magnitude.
   always_comb begin
      diff_c  = {x[DATA_W-1], x} - {prev[DATA_W-1], prev};
      absd_c  = diff_c[DATA_W] ? DATA_W'(-diff_c) : DATA_W'(diff_c);
      sum_c   = acc + FW'(absd_c);
      take_c  = x_valid & primed;
      close_c = take_c & (cnt == {WIN_LOG2{1'b1}});
      above_c = (sum_c > threshold);
      kon_c   = (k_on  == '0) ? CNT_W'(1) : k_on;
      koff_c  = (k_off == '0) ? CNT_W'(1) : k_off;
      run_inc_c = (run == {CNT_W{1'b1}}) ? run : run + CNT_W'(1);
   end

   // Sample datapath: priming, accumulation, window close and feature publish.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev          <= '0;
         acc           <= '0;
         cnt           <= '0;
         primed        <= 1'b0;
         feature       <= '0;
         feature_valid <= 1'b0;
      end else begin
         feature_valid <= 1'b0;
         if (x_valid && !primed) begin
            prev   <= x;
            primed <= 1'b1;
         end else if (take_c) begin
            prev <= x;
            cnt  <= cnt + WIN_LOG2'(1);
            if (close_c) begin
               feature       <= sum_c;
               feature_valid <= 1'b1;
               acc           <= '0;
            end else begin
               acc <= sum_c;
            end
         end
      end
   end

   // Hysteresis state register; only moves on a window close.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= QUIET;
         run    <= '0;
         detect <= 1'b0;
      end else begin
         state  <= state_nxt_c;
         run    <= run_nxt_c;
         detect <= detect_nxt_c;
      end
   end

   // Hysteresis next-state: consecutive above/not-above windows gate detect.
   always_comb begin
      state_nxt_c  = state;
      run_nxt_c    = run;
      detect_nxt_c = detect;
      if (close_c) begin
         case (state)
            QUIET: begin
               if (above_c) begin
                  if (kon_c <= CNT_W'(1)) begin
                     state_nxt_c  = ACTIVE;
                     detect_nxt_c = 1'b1;
                     run_nxt_c    = '0;
                  end else begin
                     state_nxt_c = ARMING;
                     run_nxt_c   = CNT_W'(1);
                  end
               end else begin
                  run_nxt_c = '0;
               end
            end
            ARMING: begin
               if (above_c) begin
                  if (run_inc_c >= kon_c) begin
                     state_nxt_c  = ACTIVE;
                     detect_nxt_c = 1'b1;
                     run_nxt_c    = '0;
                  end else begin
                     run_nxt_c = run_inc_c;
                  end
               end else begin
                  state_nxt_c = QUIET;
                  run_nxt_c   = '0;
               end
            end
            ACTIVE: begin
               if (!above_c) begin
                  if (koff_c <= CNT_W'(1)) begin
                     state_nxt_c  = QUIET;
                     detect_nxt_c = 1'b0;
                     run_nxt_c    = '0;
                  end else begin
                     state_nxt_c = RELEASING;
                     run_nxt_c   = CNT_W'(1);
                  end
               end else begin
                  run_nxt_c = '0;
               end
            end
            RELEASING: begin
               if (!above_c) begin
                  if (run_inc_c >= koff_c) begin
                     state_nxt_c  = QUIET;
                     detect_nxt_c = 1'b0;
                     run_nxt_c    = '0;
                  end else begin
                     run_nxt_c = run_inc_c;
                  end
               end else begin
                  state_nxt_c = ACTIVE;
                  run_nxt_c   = '0;
               end
            end
            default: begin
               state_nxt_c = QUIET;
               run_nxt_c   = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_line_length_detector.sv
// Directed bench for line_length_detector with a 4-sample window.
module tb_line_length_detector;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned WIN_LOG2 = 2;
   localparam int unsigned CNT_W    = 4;
   localparam int unsigned FW       = DATA_W + WIN_LOG2;

   logic                clk = 1'b0;
   logic                reset;
   logic signed [31:0]  x;
   logic                x_valid;
   logic [FW-1:0]       threshold;
   logic [CNT_W-1:0]    k_on;
   logic [CNT_W-1:0]    k_off;
   logic [FW-1:0]       feature;
   logic                feature_valid;
   logic                detect;
   logic                primed;

   int n_cmp    = 0;
   int n_err    = 0;
   int fv_count = 0;

   line_length_detector #(
      .DATA_W   (DATA_W),
      .WIN_LOG2 (WIN_LOG2),
      .CNT_W    (CNT_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .x             (x),
      .x_valid       (x_valid),
      .threshold     (threshold),
      .k_on          (k_on),
      .k_off         (k_off),
      .feature       (feature),
      .feature_valid (feature_valid),
      .detect        (detect),
      .primed        (primed)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   // Count feature_valid pulses away from the active edge.
   always @(negedge clk) if (feature_valid === 1'b1) fv_count++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      x_valid = 1'b0;
      x       = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // One valid sample, then outputs are observed 1 ns after the edge.
   task automatic send(input int v);
      x       = v;
      x_valid = 1'b1;
      @(posedge clk);
      #1;
      x_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      x_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   int w500 [4] = '{100, -200, 200, 0};
   int w300 [4] = '{100, -100, 100, 0};
   int feats [8] = '{500, 300, 500, 500, 300, 500, 300, 300};
   logic dets [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

   initial begin
      int cur;
      int fv0;
      reset     = 1'b0;
      x         = '0;
      x_valid   = 1'b0;
      threshold = '1;
      k_on      = 4'd1;
      k_off     = 4'd1;
      #1;

      // Test 1: basic window after reset
      do_reset();
      chk("rst_feature", 64'(feature), 64'd0);
      chk("rst_fv", 64'(feature_valid), 64'd0);
      chk("rst_detect", 64'(detect), 64'd0);
      chk("rst_primed", 64'(primed), 64'd0);
      send(0);
      chk("t1_primed", 64'(primed), 64'd1);
      chk("t1_fv_prime", 64'(feature_valid), 64'd0);
      send(100);
      send(-100);
      send(100);
      chk("t1_fv_early", 64'(feature_valid), 64'd0);
      send(100);
      chk("t1_fv", 64'(feature_valid), 64'd1);
      chk("t1_feature", 64'(feature), 64'd500);
      idle(1);
      chk("t1_fv_drop", 64'(feature_valid), 64'd0);
      chk("t1_feature_hold", 64'(feature), 64'd500);
      chk("t1_detect", 64'(detect), 64'd0);

      // Test 2: maximum swing, no wrap
      do_reset();
      send(32'sh7FFFFFFF);
      send(-32'sh80000000);
      send(32'sh7FFFFFFF);
      send(-32'sh80000000);
      send(32'sh7FFFFFFF);
      chk("t2_fv", 64'(feature_valid), 64'd1);
      chk("t2_feature", 64'(feature), 64'd17179869180);

      // Test 3: hysteresis with k_on=2, k_off=2, threshold=400
      do_reset();
      threshold = FW'(400);
      k_on      = 4'd2;
      k_off     = 4'd2;
      send(0);
      cur = 0;
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 4; j++) begin
            cur += (feats[i] == 500) ? w500[j] : w300[j];
            send(cur);
         end
         chk($sformatf("t3_feature_w%0d", i), 64'(feature), 64'(feats[i]));
         chk($sformatf("t3_detect_w%0d", i), 64'(detect), 64'(dets[i]));
      end
      idle(2);
      chk("t3_detect_final", 64'(detect), 64'd0);

      // Test 4: gaps between samples
      do_reset();
      threshold = '1;
      k_on      = 4'd1;
      k_off     = 4'd1;
      fv0 = fv_count;
      send(0);   idle(3);
      send(100); idle(3);
      send(-100); idle(3);
      send(100); idle(3);
      chk("t4_fv_early", 64'(fv_count - fv0), 64'd0);
      send(100);
      chk("t4_fv", 64'(feature_valid), 64'd1);
      chk("t4_feature", 64'(feature), 64'd500);
      idle(5);
      chk("t4_fv_count", 64'(fv_count - fv0), 64'd1);

      // Test 5: reset mid-window discards partial window
      do_reset();
      threshold = FW'(0);
      send(0);
      send(100);
      send(-100);
      fv0 = fv_count;
      do_reset();
      chk("t5_fv_none", 64'(fv_count - fv0), 64'd0);
      chk("t5_detect", 64'(detect), 64'd0);
      chk("t5_primed", 64'(primed), 64'd0);
      chk("t5_feature", 64'(feature), 64'd0);
      threshold = '1;
      send(0);
      send(100);
      send(-100);
      send(100);
      chk("t5_fv_early", 64'(feature_valid), 64'd0);
      send(100);
      chk("t5_fv", 64'(feature_valid), 64'd1);
      chk("t5_feature_new", 64'(feature), 64'd500);

      // Test 6: equality is not above; one below flips with k_on treated as 1
      do_reset();
      threshold = FW'(500);
      k_on      = 4'd1;
      send(0);
      send(100);
      send(-100);
      send(100);
      send(100);
      chk("t6_eq_feature", 64'(feature), 64'd500);
      chk("t6_eq_detect", 64'(detect), 64'd0);
      threshold = FW'(499);
      k_on      = 4'd0;
      send(200);
      send(0);
      send(200);
      chk("t6_detect_pre", 64'(detect), 64'd0);
      send(200);
      chk("t6_gt_feature", 64'(feature), 64'd500);
      chk("t6_gt_detect", 64'(detect), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Bound the run in case the sequence stalls.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
